// File: rtl/wptr_level_ctrl.sv
// Write-domain pointer controller for an async FIFO: binary/Gray write pointers,
// registered full, fill level, programmable almost-full, write-accept pulse and sticky overflow.
module wptr_level_ctrl #(
  parameter int PTR_WIDTH = 3
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   g_rptr_sync,
  input  logic [PTR_WIDTH:0]   af_thresh,
  input  logic                 ovf_clr,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic                 w_ack,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   w_level,
  output logic                 overflow
);

  localparam int PW = PTR_WIDTH;

  // Handshake: w_en is a request with no hold requirement; a request made while the
  // registered full is 0 is accepted at that edge and w_ack pulses for one cycle after it.
  // A request made while full is 1 is dropped and sets overflow.
  logic          wr_ok;
  logic [PW:0]   b_wptr_next;
  logic [PW:0]   g_wptr_next;
  logic [PW:0]   b_rptr_sync;
  logic [PW:0]   g_full_cmp;
  logic [PW:0]   level_next;

  always_comb begin
    wr_ok       = w_en & ~full;
    b_wptr_next = b_wptr + {{PW{1'b0}}, wr_ok};
    g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1);
    g_full_cmp  = {~g_rptr_sync[PW:PW-1], g_rptr_sync[PW-2:0]};
    level_next  = b_wptr_next - b_rptr_sync;
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b_rptr_sync = '0;
    for (int i = 0; i <= PW; i++) begin
      b_rptr_sync[i] = ^(g_rptr_sync >> i);
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      w_ack       <= 1'b0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      w_level     <= '0;
      overflow    <= 1'b0;
    end else begin
      b_wptr      <= b_wptr_next;
      g_wptr      <= g_wptr_next;
      w_ack       <= wr_ok;
      full        <= (g_wptr_next == g_full_cmp);
      almost_full <= (level_next >= af_thresh);
      w_level     <= level_next;
      // Set has priority over clear.
      if (w_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_level_ctrl.sv
// Scoreboard bench for wptr_level_ctrl (depth 8): a word-count model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_wptr_level_ctrl;

  localparam int PW = 3;

  logic          wclk;
  logic          wrst_n;
  logic          w_en;
  logic [PW:0]   g_rptr_sync;
  logic [PW:0]   af_thresh;
  logic          ovf_clr;
  logic [PW:0]   b_wptr;
  logic [PW:0]   g_wptr;
  logic          w_ack;
  logic          full;
  logic          almost_full;
  logic [PW:0]   w_level;
  logic          overflow;

  wptr_level_ctrl #(.PTR_WIDTH(PW)) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .w_en        (w_en),
    .g_rptr_sync (g_rptr_sync),
    .af_thresh   (af_thresh),
    .ovf_clr     (ovf_clr),
    .b_wptr      (b_wptr),
    .g_wptr      (g_wptr),
    .w_ack       (w_ack),
    .full        (full),
    .almost_full (almost_full),
    .w_level     (w_level),
    .overflow    (overflow)
  );

  // clock / reset
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  // scoreboard state: {was_reset, b_wptr, g_wptr, w_ack, full, almost_full, w_level, overflow}
  logic [16:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // reference model: counts of words written and read, wrapped at twice the depth
  int          wcnt   = 0;
  int          rd     = 0;
  bit          m_full = 0;
  bit          m_ovf  = 0;

  task automatic step(input bit rst, input bit we, input bit clr, input int thr);
    bit          ok;
    int          lvl;
    int          b;
    int          g;
    logic [16:0] e;
    @(negedge wclk);
    if (rst) rd = 0;
    wrst_n      = ~rst;
    w_en        = we;
    ovf_clr     = clr;
    af_thresh   = 4'(thr);
    g_rptr_sync = 4'(rd ^ (rd >> 1));
    @(posedge wclk);
    if (rst) begin
      wcnt   = 0;
      m_full = 0;
      m_ovf  = 0;
      e      = {1'b1, 16'h0000};
    end else begin
      ok = we && !m_full;
      if (we && m_full) m_ovf = 1;
      else if (clr)     m_ovf = 0;
      wcnt   = (wcnt + int'(ok)) % 16;
      lvl    = (wcnt - rd + 16) % 16;
      if (lvl == 0 && wcnt != rd) lvl = 16;
      m_full = (lvl == 8);
      b      = wcnt;
      g      = b ^ (b >> 1);
      e      = {1'b0, 4'(b), 4'(g), ok, m_full, (lvl >= thr), 4'(lvl), m_ovf};
    end
    exp_q.push_back(e);
  endtask

  // monitor
  logic [PW:0] prev_g = '0;
  always @(negedge wclk) begin
    logic [16:0] e;
    logic [15:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {b_wptr, g_wptr, w_ack, full, almost_full, w_level, overflow};
      n_checks++;
      if (act !== e[15:0]) begin
        n_fail++;
        $display("FAIL outputs t=%0t: b=%h g=%h ack=%b full=%b af=%b lvl=%0d ovf=%b, required b=%h g=%h ack=%b full=%b af=%b lvl=%0d ovf=%b",
                 $time, b_wptr, g_wptr, w_ack, full, almost_full, w_level, overflow,
                 e[15:12], e[11:8], e[7], e[6], e[5], e[4:1], e[0]);
      end
      if (!e[16]) begin
        n_checks++;
        if ($countones(g_wptr ^ prev_g) > 1) begin
          n_fail++;
          $display("FAIL gray_step t=%0t: g_wptr %b -> %b, required at most 1 bit change", $time, prev_g, g_wptr);
        end
      end
      prev_g = g_wptr;
    end
  end

  // stimulus
  initial begin
    int h1;
    int h2;
    int thr;
    wrst_n = 1'b0; w_en = 1'b0; ovf_clr = 1'b0; af_thresh = '0; g_rptr_sync = '0;

    // reset with a write request present
    step(1, 1, 0, 6);
    step(1, 1, 0, 6);
    // fill eight words, almost-full at six
    for (int i = 0; i < 8; i++) step(0, 1, 0, 6);
    // overflow: two rejected writes, then clear alone, then clear racing a set
    step(0, 1, 0, 6);
    step(0, 1, 0, 6);
    step(0, 0, 1, 6);
    step(0, 1, 1, 6);
    // drain one word and refill
    rd = 1;
    step(0, 0, 0, 6);
    step(0, 1, 0, 6);
    step(0, 0, 1, 6);

    // wrap: read pointer follows write pointer two cycles late
    step(1, 0, 0, 4);
    h1 = 0; h2 = 0;
    for (int i = 0; i < 40; i++) begin
      rd = h2;
      step(0, 1, 0, 4);
      h2 = h1;
      h1 = wcnt;
    end

    // threshold edges: zero asserts right after reset; eight matches full
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8);

    // random traffic, occasional reset mid-burst and out-of-range thresholds
    for (int i = 0; i < 400; i++) begin
      if (((wcnt - rd + 16) % 16) != 0 && $urandom_range(0, 2) == 0) rd = (rd + 1) % 16;
      thr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, thr);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge wclk);
    @(posedge wclk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
